// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings, default
// width and the signed-overflow rule applied to the finished result.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two's-complement overflow of a - b: operand signs differ and the
  // result sign disagrees with the minuend.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bi with borrow out bo.
module full_subtractor (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a
// single full-subtractor cell, with valid/ready operand and result handshakes.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             br_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             start_ready_r;
  logic             res_valid_r;
  logic             d_s;
  logic             bo_s;

  full_subtractor u_cell (
    .d  (d_s),
    .bo (bo_s),
    .x  (a_sh_r[0]),
    .y  (b_sh_r[0]),
    .bi (br_r)
  );

  // Handshake FSM plus serial datapath; operands are sampled only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      a_sh_r        <= '0;
      b_sh_r        <= '0;
      br_r          <= 1'b0;
      a_msb_r       <= 1'b0;
      b_msb_r       <= 1'b0;
      diff_r        <= '0;
      bout_r        <= 1'b0;
      ovf_r         <= 1'b0;
      start_ready_r <= 1'b1;
      res_valid_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_valid) begin
            a_sh_r        <= a;
            b_sh_r        <= b;
            br_r          <= bin;
            a_msb_r       <= a[WIDTH-1];
            b_msb_r       <= b[WIDTH-1];
            cnt_r         <= '0;
            start_ready_r <= 1'b0;
            state_r       <= ST_RUN;
          end else begin
            start_ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
          diff_r <= {d_s, diff_r[WIDTH-1:1]};
          br_r   <= bo_s;
          cnt_r  <= cnt_r + CNT_ONE;
          // The bit computed on this edge is the result MSB.
          if (cnt_r == CNT_LAST) begin
            bout_r      <= bo_s;
            ovf_r       <= sub_overflow(a_msb_r, b_msb_r, d_s);
            res_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_r   <= 1'b0;
            start_ready_r <= 1'b1;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          res_valid_r   <= 1'b0;
          start_ready_r <= 1'b1;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_ready = start_ready_r;
  assign res_valid   = res_valid_r;
  assign diff        = diff_r;
  assign bout        = bout_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int pass_cnt;
  int total_cnt;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .diff        (diff),
    .bout        (bout),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, scramble inputs after accept, wait (bounded) for the
  // result, capture it, then consume it with a one-cycle res_ready pulse.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic binv,
                       output int lat, output logic [7:0] d, output logic bo,
                       output logic ov);
    int w;
    w = 0;
    while (!start_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    a = av; b = bv; bin = binv; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; a = ~av; b = ~bv; bin = ~binv;
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    d = diff; bo = bout; ov = ovf;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({start_ready, res_valid, diff, bout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_in: got sr=%b rv=%b diff=%h bo=%b ov=%b, want sr=1 rv=0 diff=00 bo=0 ov=0",
               start_ready, res_valid, diff, bout, ovf);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({start_ready, res_valid} !== 2'b10)
      $display("FAIL reset_idle: got sr=%b rv=%b, want sr=1 rv=0", start_ready, res_valid);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [7:0] av [6]   = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'h00};
    logic [7:0] bv [6]   = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'h00};
    logic       biv [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed [6]   = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'hFF, 8'h00};
    logic       eb [6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       eo [6]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [7:0] d;
    logic bo, ov;
    for (int i = 0; i < 6; i++) begin
      do_op(av[i], bv[i], biv[i], lat, d, bo, ov);
      total_cnt++;
      if (lat != 8)
        $display("FAIL latency_%0d: got %0d edges, want 8", i, lat);
      else pass_cnt++;
      total_cnt++;
      if ({d, bo, ov} !== {ed[i], eb[i], eo[i]})
        $display("FAIL result_%0d: a=%h b=%h bin=%b got diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
                 i, av[i], bv[i], biv[i], d, bo, ov, ed[i], eb[i], eo[i]);
      else pass_cnt++;
      total_cnt++;
      if ({start_ready, res_valid} !== 2'b10)
        $display("FAIL handback_%0d: got sr=%b rv=%b, want sr=1 rv=0", i, start_ready, res_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int w;
    a = 8'h5A; b = 8'h3C; bin = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    w = 0;
    while (!res_valid && w < 50) begin
      @(posedge clk); #1; w++;
    end
    for (int i = 0; i < 20; i++) begin
      start_valid = ~start_valid; a = $urandom_range(255); b = $urandom_range(255);
      bin = ~bin;
      @(posedge clk); #1;
      total_cnt++;
      if ({res_valid, start_ready, diff, bout, ovf} !== {1'b1, 1'b0, 8'h1D, 1'b0, 1'b0})
        $display("FAIL hold_%0d: got rv=%b sr=%b diff=%h bo=%b ov=%b, want rv=1 sr=0 diff=1d bo=0 ov=0",
                 i, res_valid, start_ready, diff, bout, ovf);
      else pass_cnt++;
    end
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    total_cnt++;
    if ({start_ready, res_valid, diff} !== {1'b1, 1'b0, 8'h1D})
      $display("FAIL release: got sr=%b rv=%b diff=%h, want sr=1 rv=0 diff=1d",
               start_ready, res_valid, diff);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [7:0] d;
    logic bo, ov;
    a = 8'hFF; b = 8'h01; bin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({start_ready, res_valid, diff, bout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL async_reset: got sr=%b rv=%b diff=%h bo=%b ov=%b, want sr=1 rv=0 diff=00 bo=0 ov=0",
               start_ready, res_valid, diff, bout, ovf);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        @(negedge clk); rst_n = 1'b1;
      end
      total_cnt++;
      if (res_valid !== 1'b0)
        $display("FAIL no_pulse_%0d: got rv=%b, want rv=0", i, res_valid);
      else pass_cnt++;
    end
    do_op(8'hC8, 8'h64, 1'b0, lat, d, bo, ov);
    total_cnt++;
    if (lat != 8 || {d, bo, ov} !== {8'h64, 1'b0, 1'b1})
      $display("FAIL after_reset: got lat=%0d diff=%h bo=%b ov=%b, want lat=8 diff=64 bo=0 ov=1",
               lat, d, bo, ov);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, s, errs;
    logic [7:0] av, bv, d, ed;
    logic binv, bo, ov, eb, eo;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom_range(255)); bv = 8'($urandom_range(255)); binv = 1'($urandom_range(1));
      ed = 8'(int'(av) - int'(bv) - int'(binv));
      eb = (int'(av) < int'(bv) + int'(binv));
      s  = int'($signed(av)) - int'($signed(bv)) - int'(binv);
      eo = (s > 127) || (s < -128);
      do_op(av, bv, binv, lat, d, bo, ov);
      total_cnt++;
      if (lat != 8 || {d, bo, ov} !== {ed, eb, eo}) begin
        if (errs < 10)
          $display("FAIL random_%0d: a=%h b=%h bin=%b got lat=%0d diff=%h bo=%b ov=%b, want lat=8 diff=%h bo=%b ov=%b",
                   i, av, bv, binv, lat, d, bo, ov, ed, eb, eo);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    #12;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
